// File: rtl/mod_add_sub_pkg.sv
// Shared definitions for the P-384 modular add/subtract stage: widths, FSM encoding,
// adder latency and the field prime.
package mod_add_sub_pkg;

    localparam int ECC_W  = 384;
    localparam int HALF_W = ECC_W / 2;

    // Start-to-done latency of the two-phase adder, in cycles.
    localparam int L_ADD = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN1  = 3'd1,
        WAIT1 = 3'd2,
        RUN2  = 3'd3,
        WAIT2 = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [ECC_W-1:0] P384 =
        384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

endpackage

// File: rtl/mod_add_sub_if.sv
// Request/response bundle between the point-arithmetic controller and mod_add_sub.
interface mod_add_sub_if;
    import mod_add_sub_pkg::*;

    logic             start;
    logic             subtract;
    logic [ECC_W-1:0] in_a;
    logic [ECC_W-1:0] in_b;
    logic [ECC_W-1:0] in_m;
    logic [ECC_W-1:0] result;
    logic             done;
    logic             busy;

    modport master (
        output start, subtract, in_a, in_b, in_m,
        input  result, done, busy
    );

    modport slave (
        input  start, subtract, in_a, in_b, in_m,
        output result, done, busy
    );

endinterface

// File: rtl/mod_add_sub_adder.sv
// 384-bit add/subtract split into two 192-bit halves over two cycles.
// sum[384] is the carry for add and the borrow for subtract.
module mod_add_sub_adder
    import mod_add_sub_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [ECC_W-1:0] a,
    input  logic [ECC_W-1:0] b,
    output logic [ECC_W:0]   sum,
    output logic             done
);

    logic [ECC_W-1:0]  b_eff;
    logic [HALF_W:0]   lo_sum;
    logic [HALF_W:0]   hi_sum;
    logic [HALF_W-1:0] lo_reg;
    logic              carry_reg;
    logic              phase_reg;
    logic [ECC_W:0]    sum_reg;
    logic              done_reg;

    // Subtraction as a + ~b + 1; operands are held stable across both phases.
    assign b_eff  = sub ? ~b : b;
    assign lo_sum = {1'b0, a[HALF_W-1:0]} + {1'b0, b_eff[HALF_W-1:0]} + {{HALF_W{1'b0}}, sub};
    assign hi_sum = {1'b0, a[ECC_W-1:HALF_W]} + {1'b0, b_eff[ECC_W-1:HALF_W]}
                  + {{HALF_W{1'b0}}, carry_reg};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lo_reg    <= '0;
            carry_reg <= 1'b0;
            phase_reg <= 1'b0;
            sum_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            phase_reg <= start;
            done_reg  <= phase_reg;
            if (start) begin
                lo_reg    <= lo_sum[HALF_W-1:0];
                carry_reg <= lo_sum[HALF_W];
            end
            if (phase_reg) begin
                // A missing carry-out of a + ~b + 1 is a borrow.
                sum_reg <= {hi_sum[HALF_W] ^ sub, hi_sum[HALF_W-1:0], lo_reg};
            end
        end
    end

    assign sum  = sum_reg;
    assign done = done_reg;

endmodule

// File: rtl/mod_add_sub.sv
// Modular add/subtract: pass 1 forms a +/- b, pass 2 applies the -/+ m correction,
// then selects the reduced value. A single adder is time-shared by both passes.
module mod_add_sub
    import mod_add_sub_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mod_add_sub_if.slave bus
);

    state_t           state_reg, state_next;
    logic [ECC_W-1:0] a_reg, b_reg, m_reg;
    logic             sub_reg;
    logic [ECC_W:0]   s_reg;
    logic [ECC_W-1:0] result_reg;

    logic             pass2;
    logic             add_start, add_sub, add_done;
    logic [ECC_W-1:0] add_a, add_b;
    logic [ECC_W:0]   add_sum;
    logic             take_t;
    logic [ECC_W-1:0] pick;

    assign pass2     = (state_reg == RUN2) || (state_reg == WAIT2);
    assign add_start = (state_reg == RUN1) || (state_reg == RUN2);
    assign add_a     = pass2 ? s_reg[ECC_W-1:0] : a_reg;
    assign add_b     = pass2 ? m_reg : b_reg;
    assign add_sub   = pass2 ? ~sub_reg : sub_reg;

    mod_add_sub_adder u_adder (
        .clk    (clk),
        .resetn (~reset),
        .start  (add_start),
        .sub    (add_sub),
        .a      (add_a),
        .b      (add_b),
        .sum    (add_sum),
        .done   (add_done)
    );

    // Bit 384 of s and t is only a select flag; the value itself wraps at 2^384.
    assign take_t = sub_reg ? s_reg[ECC_W] : (s_reg[ECC_W] | ~add_sum[ECC_W]);
    assign pick   = take_t ? add_sum[ECC_W-1:0] : s_reg[ECC_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            sub_reg    <= 1'b0;
            s_reg      <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.start) begin
                a_reg   <= bus.in_a;
                b_reg   <= bus.in_b;
                m_reg   <= bus.in_m;
                sub_reg <= bus.subtract;
            end
            if (state_reg == WAIT1 && add_done) begin
                s_reg <= add_sum;
            end
            if (state_reg == WAIT2 && add_done) begin
                result_reg <= pick;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN1;
            RUN1:    state_next = WAIT1;
            WAIT1:   if (add_done) state_next = RUN2;
            RUN2:    state_next = WAIT2;
            WAIT2:   if (add_done) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.result = result_reg;
    assign bus.done   = (state_reg == FIN);
    assign bus.busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mod_add_sub.sv
// Directed-vector bench for mod_add_sub with m = P-384 throughout.
module tb_mod_add_sub;

    localparam logic [383:0] P =
        384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;
    localparam int LAT = 7;  // 2*L_ADD + 3 with L_ADD = 2

    typedef struct {
        string        name;
        logic         sub;
        logic [383:0] a;
        logic [383:0] b;
        logic [383:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    mod_add_sub_if bus ();

    mod_add_sub dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic sub, input logic [383:0] a, input logic [383:0] b,
                          output logic [383:0] res, output int lat, output int pulses,
                          output int busy1);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.subtract = sub;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_m     = P;
        @(posedge clk);
        #1;
        // Scramble the ports after capture; the stage must not re-read them.
        bus.start    = 1'b0;
        bus.subtract = ~sub;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_m     = 384'd12345;
        busy1  = int'(bus.busy);
        res    = '0;
        lat    = 0;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                pulses++;
                if (lat == 0) begin
                    lat = c;
                    res = bus.result;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         vecs[7];
        logic [383:0] res;
        logic [383:0] p_m1;
        logic [383:0] p_m2;
        int           lat, pulses, busy1, dones, busy_late;

        p_m1 = P - 384'd1;
        p_m2 = P - 384'd2;
        vecs[0] = '{"add_1_2",       1'b0, 384'd1, 384'd2, 384'd3};
        vecs[1] = '{"add_pm1_1",     1'b0, p_m1,   384'd1, 384'd0};
        vecs[2] = '{"add_pm1_pm1",   1'b0, p_m1,   p_m1,   p_m2};
        vecs[3] = '{"sub_1_2",       1'b1, 384'd1, 384'd2, p_m1};
        vecs[4] = '{"sub_5_5",       1'b1, 384'd5, 384'd5, 384'd0};
        vecs[5] = '{"sub_pm1_0",     1'b1, p_m1,   384'd0, p_m1};
        vecs[6] = '{"add_0_0",       1'b0, 384'd0, 384'd0, 384'd0};

        bus.start = 1'b0; bus.subtract = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_m = P;

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", bus.result, 384'd0);
        check("reset_done", {383'd0, bus.done}, 384'd0);
        check("reset_busy", {383'd0, bus.busy}, 384'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, res, lat, pulses, busy1);
            $display("vec %0d %s: result=%h latency=%0d", i, vecs[i].name, res, lat);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 384'(lat), 384'(LAT));
            check({vecs[i].name, "_pulses"}, 384'(pulses), 384'd1);
            check({vecs[i].name, "_busy"}, 384'(busy1), 384'd1);
        end

        // Second start during WAIT1 is dropped; a start in the FIN cycle is not accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.subtract = 1'b0;
        bus.in_a = 384'd7; bus.in_b = 384'd3; bus.in_m = P;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0; busy_late = 0; res = '0; lat = 0;
        for (int c = 1; c <= 30; c++) begin
            if (bus.done) begin
                dones++;
                lat = c;
                res = bus.result;
            end
            if (c >= 8 && bus.busy) busy_late++;
            bus.start = 1'b0;
            if (c == 2) begin
                bus.start = 1'b1; bus.in_a = 384'd100; bus.in_b = 384'd200;
            end
            if (c == LAT) begin
                bus.start = 1'b1; bus.in_a = 384'd50; bus.in_b = 384'd60;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        $display("busy_reject: result=%h dones=%0d latency=%0d", res, dones, lat);
        check("busy_reject_result", res, 384'd10);
        check("busy_reject_dones", 384'(dones), 384'd1);
        check("busy_reject_latency", 384'(lat), 384'(LAT));
        check("fin_start_ignored", 384'(busy_late), 384'd0);

        // Reset during WAIT2 abandons the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.subtract = 1'b0;
        bus.in_a = 384'd11; bus.in_b = 384'd22; bus.in_m = P;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int c = 1; c < 5; c++) begin
            if (bus.done) dones++;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("reset_mid: busy=%0b result=%h done=%0b", bus.busy, bus.result, bus.done);
        check("reset_mid_busy", {383'd0, bus.busy}, 384'd0);
        check("reset_mid_result", bus.result, 384'd0);
        check("reset_mid_done", {383'd0, bus.done}, 384'd0);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (bus.done) dones++;
            @(posedge clk);
            #1;
        end
        check("reset_mid_no_done", 384'(dones), 384'd0);

        run_op(1'b0, 384'd4, 384'd4, res, lat, pulses, busy1);
        $display("after_reset add_4_4: result=%h latency=%0d", res, lat);
        check("after_reset_result", res, 384'd8);
        check("after_reset_latency", 384'(lat), 384'(LAT));
        check("after_reset_pulses", 384'(pulses), 384'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
